// File: rtl/reg_file_rename_if.sv
// Dispatcher/ROB-facing bundle for the register file and rename table.
// The master modport drives commits, renames and lookups; the slave answers lookups.
interface reg_file_rename_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
);
  logic             rdy;
  logic             rollback;
  logic             commit_valid;
  logic [4:0]       commit_reg_id;
  logic [TAG_W-1:0] commit_alias;
  logic [XLEN-1:0]  commit_result;
  logic             rename_valid;
  logic [4:0]       rename_rd;
  logic [TAG_W-1:0] rename_alias;
  logic [4:0]       rs1_id;
  logic [4:0]       rs2_id;
  logic [XLEN-1:0]  rs1_val;
  logic [XLEN-1:0]  rs2_val;
  logic [TAG_W-1:0] rs1_tag;
  logic [TAG_W-1:0] rs2_tag;

  modport master (
    output rdy, rollback,
    output commit_valid, commit_reg_id, commit_alias, commit_result,
    output rename_valid, rename_rd, rename_alias,
    output rs1_id, rs2_id,
    input  rs1_val, rs2_val, rs1_tag, rs2_tag
  );

  modport slave (
    input  rdy, rollback,
    input  commit_valid, commit_reg_id, commit_alias, commit_result,
    input  rename_valid, rename_rd, rename_alias,
    input  rs1_id, rs2_id,
    output rs1_val, rs2_val, rs1_tag, rs2_tag
  );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file + rename tags; one-cycle writes, zero-latency reads with commit bypass.
// No backpressure: rdy low freezes all state while reads stay combinational.
module reg_file_rename #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4
) (
  input logic             clk,
  input logic             rst,
  reg_file_rename_if.slave rf
);

  logic [XLEN-1:0]  val_q [32];
  logic [XLEN-1:0]  val_d [32];
  logic [TAG_W-1:0] tag_q [32];
  logic [TAG_W-1:0] tag_d [32];

  logic commit_en;
  logic rename_en;

  assign commit_en = rf.commit_valid && (rf.commit_reg_id != 5'd0);
  assign rename_en = rf.rename_valid && (rf.rename_rd != 5'd0) && !rf.rollback;

  always_comb begin
    val_d = val_q;
    tag_d = tag_q;
    if (rf.rdy) begin
      // Commit clears the tag only if it is still the newest producer.
      if (commit_en) begin
        val_d[rf.commit_reg_id] = rf.commit_result;
        if (tag_q[rf.commit_reg_id] == rf.commit_alias) begin
          tag_d[rf.commit_reg_id] = '0;
        end
      end
      if (rf.rollback) begin
        for (int i = 0; i < 32; i++) begin
          tag_d[i] = '0;
        end
      end else if (rename_en) begin
        tag_d[rf.rename_rd] = rf.rename_alias;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 32; i++) begin
        val_q[i] <= val_d[i];
        tag_q[i] <= tag_d[i];
      end
    end
  end

  function automatic logic [TAG_W+XLEN-1:0] lookup(
    input logic [4:0]       id,
    input logic [XLEN-1:0]  cur_val,
    input logic [TAG_W-1:0] cur_tag,
    input logic             c_vld,
    input logic [4:0]       c_id,
    input logic [TAG_W-1:0] c_alias,
    input logic [XLEN-1:0]  c_res
  );
    logic [TAG_W+XLEN-1:0] res;
    res = {cur_tag, cur_val};
    if (id == 5'd0) begin
      res = '0;
    end else if (c_vld && (c_id == id) && (cur_tag == c_alias)) begin
      res = {{TAG_W{1'b0}}, c_res};
    end
    return res;
  endfunction

  // Same-cycle renames are deliberately invisible here: reads see the older producer.
  assign {rf.rs1_tag, rf.rs1_val} = lookup(rf.rs1_id, val_q[rf.rs1_id], tag_q[rf.rs1_id],
                                           rf.commit_valid, rf.commit_reg_id,
                                           rf.commit_alias, rf.commit_result);
  assign {rf.rs2_tag, rf.rs2_val} = lookup(rf.rs2_id, val_q[rf.rs2_id], tag_q[rf.rs2_id],
                                           rf.commit_valid, rf.commit_reg_id,
                                           rf.commit_alias, rf.commit_result);

endmodule

// File: doc/reg_file_rename.md
# reg_file_rename

Architectural register file and rename-tag table for the Tomasulo core. It accepts in-order commits from the reorder buffer and records destination renames from the dispatcher. It answers the dispatcher's two source-operand lookups combinationally, returning either a committed value or the ROB tag that will produce it. On ROB rollback it drops every pending rename.

## Interface
Parameters:
- XLEN, 32, data width.
- TAG_W, 4, ROB tag width. Tag 0 is reserved and means "no dependency". The ROB never issues tag 0.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; when low, all state holds.
- rollback  in  1  mispredict flush from the ROB.
- commit_valid  in  1  ROB commit strobe.
- commit_reg_id  in  5  destination architectural register of the commit.
- commit_alias  in  TAG_W  ROB tag of the committing entry.
- commit_result  in  XLEN  committed value.
- rename_valid  in  1  dispatcher allocates a ROB entry with a destination.
- rename_rd  in  5  destination register being renamed.
- rename_alias  in  TAG_W  ROB tag assigned to that destination.
- rs1_id, rs2_id  in  5 each  source register indices from the dispatcher.
- rs1_val, rs2_val  out  XLEN each  source value; meaningful only when the matching tag output is 0.
- rs1_tag, rs2_tag  out  TAG_W each  pending producer tag; 0 means the value output is final.

## Operation
- State:
  - val[0..31], each XLEN bits.
  - tag[0..31], each TAG_W bits.
  - x0 is hard-wired: never written, val 0, tag 0.
- Update rules, evaluated at posedge when rst=0 and rdy=1:
  - **Commit.** Applies when commit_valid=1 and commit_reg_id≠0.
    - val[commit_reg_id] <= commit_result.
    - If tag[commit_reg_id]==commit_alias, tag[commit_reg_id] <= 0.
    - Otherwise the tag is kept, because a younger rename is still outstanding.
  - **Rename.** Applies when rename_valid=1, rename_rd≠0 and rollback=0.
    - tag[rename_rd] <= rename_alias.
    - Rename has priority over the commit tag-clear when both target the same register in the same cycle. The value write from the commit still happens.
  - **Rollback.** Applies when rollback=1.
    - All tags <= 0 and rename is ignored.
    - A commit presented in the same cycle still writes its value, because the ROB asserts its final commit alongside rollback.
- rdy=0: no state changes. Reads stay combinational on the current state.
- Read path, per source s ∈ {rs1, rs2}, fully combinational:
  - s_id==0 → val 0, tag 0.
  - Else if commit_valid and commit_reg_id==s_id and tag[s_id]==commit_alias, a same-cycle commit bypass applies → val=commit_result, tag 0.
  - Else val=val[s_id], tag=tag[s_id].
  - A rename in the same cycle does not affect the read. An instruction such as add x1,x1,x2 therefore sees x1's older producer.
- The bypass is not gated by rdy. The dispatcher only consumes the read when rdy=1.

## Timing
- Reset: all val=0 and all tag=0 one cycle after rst is sampled high. Immediately afterwards, all read outputs give 0/0.
- Write latency: one cycle. A commit or rename at edge N is visible on reads after edge N.
- Read latency: zero (combinational). The commit bypass gives zero-latency visibility of the commit value.
- Reset mid-operation takes precedence over rollback, commit and rename in the same cycle.
- Tag wrap-around: tags are opaque. Correctness relies only on equality comparison and on the ROB never issuing two live entries with the same tag.

## Test plan
- **Reset.** Assert rst one cycle, then read x5 and x31 → val 0, tag 0. Attempt a commit to x0 with value 0xDEADBEEF → rs1_id=0 still reads 0/0.
- **Rename then commit.**
  - Rename x3→tag 2; next cycle rs1_id=3 → tag 2.
  - Commit (x3, alias 2, 0x1234); same cycle rs1 → val 0x1234, tag 0 via bypass.
  - Next cycle reads 0x1234/0 from state.
- **Stale commit.** Rename x4→tag 1, then rename x4→tag 3. Commit (x4, alias 1, 0x55) → val[x4]=0x55 but tag stays 3. rs2_id=4 → tag 3.
- **Collision.** With tag[x6]=5, in one cycle commit (x6, alias 5, 0x77) and rename x6→tag 7. Next cycle: tag 7, val 0x77. The same-cycle read of x6 returns 0x77/0 (bypass; rename not yet visible).
- **Rollback.**
  - Set tags x1=2, x2=3, x9=4.
  - In one cycle assert rollback together with a commit (x9, alias 4, 0xAA) and a rename x1→6.
  - Next cycle all three registers read tag 0. x9 reads 0xAA. x1 keeps its prior value.
- **Stall.** With rdy=0 present commit (x8, alias 1, 0x99) and rename x8→2 → no state change. After rdy returns to 1 with inputs deasserted, x8 reads its old value and old tag.
